// File: rtl/pwm_cfg_sequencer_if.sv
// Register-write bus and PWM-core handshake between the I2C front end,
// the configuration sequencer and the PWM counter.
interface pwm_cfg_sequencer_if #(
  parameter int REGBITS  = 2,
  parameter int DUTYBITS = 16
);
  logic [REGBITS-1:0]  regAddr;
  logic [7:0]          regData;
  logic                regDataValid;
  logic                period_end;
  logic [DUTYBITS-1:0] duty;
  logic [7:0]          prescale;
  logic                pwm_en;
  logic                cfg_update;
  logic                pending;

  modport master (
    output regAddr, regData, regDataValid, period_end,
    input  duty, prescale, pwm_en, cfg_update, pending
  );

  modport slave (
    input  regAddr, regData, regDataValid, period_end,
    output duty, prescale, pwm_en, cfg_update, pending
  );
endinterface

// File: rtl/pwm_cfg_sequencer.sv
// Shadow/active PWM configuration bank: register writes land in the shadow
// bank and a COMMIT copies them to the active outputs on a period boundary.
module pwm_cfg_sequencer #(
  parameter int                  REGBITS    = 2,
  parameter int                  DUTYBITS   = 16,
  parameter logic [DUTYBITS-1:0] DUTY_RESET = DUTYBITS'(16'h8000)
) (
  input logic                clk,
  input logic                rst,
  pwm_cfg_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    APPLY
  } state_t;

  state_t state_q, state_d;

  logic [DUTYBITS-1:0] sh_duty, duty_q;
  logic [7:0]          sh_prescale, prescale_q;
  logic                sh_en, en_q;
  logic                cfg_update_q, pending_q;

  logic wr_duty_lo, wr_duty_hi, wr_ctrl, wr_prescale;
  logic commit_req, abort_req, reload;

  // Address decode; any address outside the four-entry map is dropped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_duty_lo  = 1'b0;
    wr_duty_hi  = 1'b0;
    wr_ctrl     = 1'b0;
    wr_prescale = 1'b0;
    if (bus.regDataValid) begin
      case (bus.regAddr)
        REGBITS'(0): wr_duty_lo  = 1'b1;
        REGBITS'(1): wr_duty_hi  = 1'b1;
        REGBITS'(2): wr_ctrl     = 1'b1;
        REGBITS'(3): wr_prescale = 1'b1;
        default:     ;
      endcase
    end
  end

  assign abort_req  = wr_ctrl & bus.regData[2];
  assign commit_req = wr_ctrl & bus.regData[1] & ~bus.regData[2];
  // APPLY is busy copying shadow to active, so an abort there is a no-op.
  assign reload     = abort_req & (state_q != APPLY);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (commit_req) state_d = ARMED;
      ARMED: begin
        if (abort_req)                        state_d = IDLE;
        else if (bus.period_end || !en_q)     state_d = APPLY;
      end
      APPLY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_duty      <= DUTY_RESET;
      sh_prescale  <= '0;
      sh_en        <= 1'b0;
      duty_q       <= DUTY_RESET;
      prescale_q   <= '0;
      en_q         <= 1'b0;
      cfg_update_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      cfg_update_q <= (state_q == APPLY);
      pending_q    <= (state_d != IDLE);

      if (state_q == APPLY) begin
        duty_q     <= sh_duty;
        prescale_q <= sh_prescale;
        en_q       <= sh_en;
      end

      if (wr_duty_lo)  sh_duty[7:0]          <= bus.regData;
      if (wr_duty_hi)  sh_duty[DUTYBITS-1:8] <= bus.regData[DUTYBITS-9:0];
      if (wr_prescale) sh_prescale           <= bus.regData;
      // The enable bit of a CTRL write is taken even when it also aborts.
      if (wr_ctrl)     sh_en                 <= bus.regData[0];

      if (reload) begin
        sh_duty     <= duty_q;
        sh_prescale <= prescale_q;
      end
    end
  end

  assign bus.duty       = duty_q;
  assign bus.prescale   = prescale_q;
  assign bus.pwm_en     = en_q;
  assign bus.cfg_update = cfg_update_q;
  assign bus.pending    = pending_q;

endmodule
